// File: rtl/bus_initiator.sv
// Purpose : single-outstanding register-bus initiator; turns a req command into a
//           cs/we/address/write_data access and returns the result on rsp.
// Latency : accept edge E0, cs high from E0, ready sampled at the next edge(s),
//           response presented the cycle after; 3 cycles minimum end to end.
// Backpressure: req_ready is high only in IDLE. A response is held in RESP
//           until rsp_ready; the bus access ends on ready or after TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   req_valid/req_ready              command handshake
//   req_we, req_addr, req_wdata      command fields (sampled only in IDLE)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_timeout           response payload (rdata is 0 for writes/timeouts)
//   cs, we, address, write_data      registered peripheral strobe/controls
//   read_data, ready                 peripheral return; ready may be combinational from cs
//   busy                             high whenever a transaction is in flight

module bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic        cs,
  output logic        we,
  output logic [7:0]  address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  input  logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter value at which the access is abandoned. The compare happens before
  // the increment, so cs stays high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_nxt;
  logic        cs_nxt;
  logic        we_nxt;
  logic [7:0]  address_nxt;
  logic [31:0] write_data_nxt;
  logic [31:0] rsp_rdata_nxt;
  logic        rsp_timeout_nxt;

  // Handshake/status outputs decode straight from the state register.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tmo_cnt     <= 16'd0;
      cs          <= 1'b0;
      we          <= 1'b0;
      address     <= 8'd0;
      write_data  <= 32'd0;
      rsp_rdata   <= 32'd0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      cs          <= cs_nxt;
      we          <= we_nxt;
      address     <= address_nxt;
      write_data  <= write_data_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_nxt       = state;
    tmo_cnt_nxt     = tmo_cnt;
    cs_nxt          = cs;
    we_nxt          = we;
    address_nxt     = address;
    write_data_nxt  = write_data;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      IDLE: begin
        if (req_valid) begin
          cs_nxt         = 1'b1;
          we_nxt         = req_we;
          address_nxt    = req_addr;
          write_data_nxt = req_wdata;
          tmo_cnt_nxt    = 16'd0;
          state_nxt      = ACCESS;
        end
      end

      ACCESS: begin
        // ready is checked first so it wins over a timeout on the same edge.
        if (ready) begin
          rsp_rdata_nxt   = we ? 32'd0 : read_data;
          rsp_timeout_nxt = 1'b0;
          cs_nxt          = 1'b0;
          we_nxt          = 1'b0;
          address_nxt     = 8'd0;
          write_data_nxt  = 32'd0;
          state_nxt       = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_rdata_nxt   = 32'd0;
          rsp_timeout_nxt = 1'b1;
          cs_nxt          = 1'b0;
          we_nxt          = 1'b0;
          address_nxt     = 8'd0;
          write_data_nxt  = 32'd0;
          state_nxt       = RESP;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 16'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        // Unreachable encoding: park cleanly in IDLE with the bus released.
        state_nxt      = IDLE;
        cs_nxt         = 1'b0;
        we_nxt         = 1'b0;
        address_nxt    = 8'd0;
        write_data_nxt = 32'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: a small register-file responder whose ready
// timing is selectable (immediate, delayed by N cycles, never), driven by a
// linear sequence of transactions with hand-computed expectations.

module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .busy       (busy)
  );

  // Responder: mode 0 ready=cs, mode 1 ready on cs cycle index resp_delay, mode 2 never.
  logic [31:0] mem [0:255];
  int          resp_mode  = 0;
  int          resp_delay = 0;
  logic        use_fixed  = 1'b0;
  logic [31:0] fixed_rdata = 32'd0;
  int          cs_age = 0;

  always @(posedge clk) begin
    if (cs) cs_age <= cs_age + 1;
    else    cs_age <= 0;
    if (cs && ready && we) mem[address] <= write_data;
  end

  assign ready = cs && ((resp_mode == 0) || (resp_mode == 1 && cs_age == resp_delay));
  assign read_data = use_fixed ? fixed_rdata : mem[address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction. hold = cycles rsp_ready stays low once the response is up.
  task automatic do_txn(input string tag, input logic t_we, input logic [7:0] t_addr,
                        input logic [31:0] t_wdata, input int hold, input int exp_cs,
                        input logic [31:0] exp_rdata, input logic exp_tmo);
    int   cycles;
    logic bus_ok;
    logic hold_ok;
    @(negedge clk);
    check($sformatf("%s_req_ready_idle", tag), {31'd0, req_ready}, 32'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = t_we;
    req_addr  = t_addr;
    req_wdata = t_wdata;
    @(negedge clk);
    req_valid = 1'b0;
    cycles = 0;
    bus_ok = 1'b1;
    while (cs === 1'b1 && cycles < 400) begin
      cycles++;
      if (we !== t_we || address !== t_addr || write_data !== t_wdata ||
          busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
        bus_ok = 1'b0;
      // Scramble the command fields while the access is in flight.
      req_we    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = $urandom;
      @(negedge clk);
    end
    check($sformatf("%s_cs_cycles", tag), 32'(cycles), 32'(exp_cs));
    check($sformatf("%s_bus_stable", tag), {31'd0, bus_ok}, 32'd1);
    check($sformatf("%s_rsp_valid", tag), {31'd0, rsp_valid}, 32'd1);
    check($sformatf("%s_rsp_rdata", tag), rsp_rdata, exp_rdata);
    check($sformatf("%s_rsp_timeout", tag), {31'd0, rsp_timeout}, {31'd0, exp_tmo});
    check($sformatf("%s_bus_idle_zero", tag), {23'd0, we, address} | write_data, 32'd0);
    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_timeout !== exp_tmo ||
            req_ready !== 1'b0 || busy !== 1'b1 || cs !== 1'b0)
          hold_ok = 1'b0;
        @(negedge clk);
      end
      check($sformatf("%s_rsp_hold", tag), {31'd0, hold_ok}, 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    check($sformatf("%s_back_idle", tag), {29'd0, req_ready, rsp_valid, busy}, 32'b100);
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h01010101;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_cs", {31'd0, cs}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_bus", {23'd0, we, address} | write_data, 32'd0);
    check("rst_rsp", rsp_rdata | {31'd0, rsp_timeout}, 32'd0);
    reset_n = 1'b1;

    // Write then read-back with ready=cs; rsp_ready high gives the 3-cycle path.
    resp_mode = 0;
    do_txn("wr0a", 1'b1, 8'h0a, 32'h00000010, 0, 1, 32'h0, 1'b0);
    do_txn("rd0a", 1'b0, 8'h0a, 32'h0, 0, 1, 32'h00000010, 1'b0);

    // Ready delayed 5 cycles
    resp_mode = 1; resp_delay = 5; use_fixed = 1'b1; fixed_rdata = 32'hDEADBEEF;
    do_txn("rd_dly5", 1'b0, 8'h33, 32'h0, 0, 6, 32'hDEADBEEF, 1'b0);

    // Timeout with ready never rising; read_data is non-zero but must not be latched
    resp_mode = 2; fixed_rdata = 32'h12345678;
    do_txn("rd_tmo", 1'b0, 8'h44, 32'h0, 0, 255, 32'h0, 1'b1);

    // Ready arrives on the 255th cs cycle: ready wins over the timeout
    resp_mode = 1; resp_delay = 254; fixed_rdata = 32'hCAFEF00D;
    do_txn("rd_tmo_race", 1'b0, 8'h45, 32'h0, 0, 255, 32'hCAFEF00D, 1'b0);

    // Response backpressure for 10 cycles
    resp_mode = 0; use_fixed = 1'b0;
    do_txn("rd_hold10", 1'b0, 8'h0a, 32'h0, 10, 1, 32'h00000010, 1'b0);

    // Reset during ACCESS
    resp_mode = 2;
    begin
      logic quiet;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h21; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rstacc_cs_before", {31'd0, cs}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check("rstacc_cs", {31'd0, cs}, 32'd0);
      check("rstacc_flags", {29'd0, req_ready, rsp_valid, busy}, 32'b100);
      reset_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (rsp_valid !== 1'b0 || cs !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        @(negedge clk);
      end
      check("rstacc_no_rsp", {31'd0, quiet}, 32'd1);
    end

    // Reset while a response is pending
    resp_mode = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h0a; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstrsp_valid_before", {31'd0, rsp_valid}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstrsp_flags", {29'd0, req_ready, rsp_valid, busy}, 32'b100);
    check("rstrsp_rdata", rsp_rdata, 32'd0);
    reset_n = 1'b1;

    // Recovery: full write/read after the resets
    do_txn("wr55", 1'b1, 8'h55, 32'hA5A55A5A, 2, 1, 32'h0, 1'b0);
    do_txn("rd55", 1'b0, 8'h55, 32'h0, 0, 1, 32'hA5A55A5A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
